// File: rtl/es_nios2_div_cell_pkg.sv
// Shared types and constants for the Nios II restoring divider cell.
package es_nios2_div_pkg;
    typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} div_state_t;
    localparam int DIV_WIDTH = 32;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/es_nios2_div_cell_if.sv
// A-stage request/result bundle between the pipeline and the divider cell.
interface es_nios2_div_cell_if import es_nios2_div_pkg::*; #(parameter int WIDTH = DIV_WIDTH);
    logic             A_div_start;
    logic             A_div_signed;
    logic [WIDTH-1:0] A_div_src1;
    logic [WIDTH-1:0] A_div_src2;
    logic             A_div_busy;
    logic             A_div_done;
    logic [WIDTH-1:0] A_div_quotient;
    logic [WIDTH-1:0] A_div_remainder;
    logic             A_div_by_zero;

    modport master (
        output A_div_start, A_div_signed, A_div_src1, A_div_src2,
        input  A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
    );
    modport slave (
        input  A_div_start, A_div_signed, A_div_src1, A_div_src2,
        output A_div_busy, A_div_done, A_div_quotient, A_div_remainder, A_div_by_zero
    );
endinterface

// File: rtl/es_nios2_div_cell_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
module es_nios2_div_step import es_nios2_div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH:0]   next_rem,
    output logic             q_bit
);
    logic [WIDTH+1:0] wide;
    logic [WIDTH:0]   shifted;

    assign wide     = {rem, dvd_msb};
    assign shifted  = wide[WIDTH:0];
    assign q_bit    = (wide >= {2'b00, dsr});
    assign next_rem = q_bit ? (shifted - {1'b0, dsr}) : shifted;
endmodule

// File: rtl/es_nios2_div_cell.sv
// Multi-cycle signed/unsigned divider: magnitudes in, one quotient bit per clock, sign fixup out.
module es_nios2_div_cell import es_nios2_div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
    input logic               clk,
    input logic               reset,
    es_nios2_div_cell_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("es_nios2_div_cell: WIDTH must be even and >= 4");
    end

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] src1_l, src2_l, dvd, dsr;
    logic [WIDTH:0]   rem, next_rem;
    logic             sgn_l, q_neg, r_neg, dz, q_bit;

    es_nios2_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_msb  (dvd[WIDTH-1]),
        .dsr      (dsr),
        .next_rem (next_rem),
        .q_bit    (q_bit)
    );

    // dvd doubles as the quotient accumulator: dividend bits shift out the top, quotient bits in the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            count               <= '0;
            src1_l              <= '0;
            src2_l              <= '0;
            sgn_l               <= 1'b0;
            dvd                 <= '0;
            dsr                 <= '0;
            rem                 <= '0;
            q_neg               <= 1'b0;
            r_neg               <= 1'b0;
            dz                  <= 1'b0;
            bus.A_div_busy      <= 1'b0;
            bus.A_div_done      <= 1'b0;
            bus.A_div_quotient  <= '0;
            bus.A_div_remainder <= '0;
            bus.A_div_by_zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.A_div_start) begin
                        src1_l         <= bus.A_div_src1;
                        src2_l         <= bus.A_div_src2;
                        sgn_l          <= bus.A_div_signed;
                        bus.A_div_busy <= 1'b1;
                        state          <= PREP;
                    end
                end
                PREP: begin
                    dvd   <= (sgn_l && src1_l[WIDTH-1]) ? -src1_l : src1_l;
                    dsr   <= (sgn_l && src2_l[WIDTH-1]) ? -src2_l : src2_l;
                    q_neg <= sgn_l && (src1_l[WIDTH-1] ^ src2_l[WIDTH-1]);
                    r_neg <= sgn_l && src1_l[WIDTH-1];
                    dz    <= (src2_l == '0);
                    rem   <= '0;
                    count <= '0;
                    state <= (src2_l == '0) ? FIXUP : ITER;
                end
                ITER: begin
                    rem   <= next_rem;
                    dvd   <= {dvd[WIDTH-2:0], q_bit};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH-1)) state <= FIXUP;
                end
                FIXUP: begin
                    if (dz) begin
                        bus.A_div_quotient  <= WIDTH'(DIV0_QUOTIENT);
                        bus.A_div_remainder <= src1_l;
                    end else begin
                        bus.A_div_quotient  <= q_neg ? -dvd : dvd;
                        bus.A_div_remainder <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
                    end
                    bus.A_div_by_zero <= dz;
                    bus.A_div_done    <= 1'b1;
                    state             <= DONE;
                end
                DONE: begin
                    bus.A_div_done <= 1'b0;
                    bus.A_div_busy <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_es_nios2_div_cell.sv
// Directed-vector bench for the divider cell; inputs driven and outputs sampled on the falling edge.
module tb_es_nios2_div_cell;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    es_nios2_div_cell_if #(.WIDTH(32)) bus ();
    es_nios2_div_cell #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Present a one-cycle start; returns half a cycle after the accept edge (cycle 1).
    task automatic pulse_start(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.A_div_start  = 1'b1;
        bus.A_div_signed = sgn;
        bus.A_div_src1   = a;
        bus.A_div_src2   = b;
        @(negedge clk);
        bus.A_div_start  = 1'b0;
    endtask

    // Count cycles from 'first' until done, tallying cycles where busy was not high.
    task automatic wait_done(input int first, output int lat, output int busy_bad);
        lat = first;
        busy_bad = 0;
        while (bus.A_div_done !== 1'b1 && lat < 100) begin
            if (bus.A_div_busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        if (bus.A_div_busy !== 1'b1) busy_bad++;
    endtask

    task automatic check_op(input string name, input int lat, input int busy_bad, input int exp_lat,
                            input logic [31:0] eq, input logic [31:0] er, input logic ez);
        checks++;
        if (lat !== exp_lat) begin errors++; $display("FAIL %s latency got %0d want %0d", name, lat, exp_lat); end
        checks++;
        if (busy_bad !== 0) begin errors++; $display("FAIL %s busy low in %0d cycles want 0", name, busy_bad); end
        checks++;
        if (bus.A_div_quotient !== eq) begin errors++; $display("FAIL %s quotient got %h want %h", name, bus.A_div_quotient, eq); end
        checks++;
        if (bus.A_div_remainder !== er) begin errors++; $display("FAIL %s remainder got %h want %h", name, bus.A_div_remainder, er); end
        checks++;
        if (bus.A_div_by_zero !== ez) begin errors++; $display("FAIL %s by_zero got %b want %b", name, bus.A_div_by_zero, ez); end
        @(negedge clk);
        checks++;
        if (bus.A_div_busy !== 1'b0 || bus.A_div_done !== 1'b0) begin
            errors++; $display("FAIL %s after-done busy=%b done=%b want 0 0", name, bus.A_div_busy, bus.A_div_done);
        end
        checks++;
        if (bus.A_div_quotient !== eq || bus.A_div_remainder !== er) begin
            errors++; $display("FAIL %s hold q=%h r=%h want %h %h", name, bus.A_div_quotient, bus.A_div_remainder, eq, er);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.A_div_busy, bus.A_div_done, bus.A_div_by_zero, bus.A_div_quotient, bus.A_div_remainder} !== 67'd0) begin
            errors++; $display("FAIL reset outputs busy=%b done=%b q=%h r=%h want all 0",
                               bus.A_div_busy, bus.A_div_done, bus.A_div_quotient, bus.A_div_remainder);
        end
        reset = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat, bb;
        pulse_start(1'b0, 32'd100, 32'd7);
        wait_done(1, lat, bb);
        check_op("udiv_100_7", lat, bb, 35, 32'd14, 32'd2, 1'b0);
    endtask

    task automatic test_signed;
        int lat, bb;
        pulse_start(1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat, bb);
        check_op("sdiv_m7_2", lat, bb, 35, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        pulse_start(1'b0, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat, bb);
        check_op("udiv_m7_2", lat, bb, 35, 32'h7FFF_FFFC, 32'd1, 1'b0);
    endtask

    task automatic test_div_by_zero;
        int lat, bb;
        for (int m = 0; m < 2; m++) begin
            pulse_start(m[0], 32'd5, 32'd0);
            wait_done(1, lat, bb);
            check_op(m == 0 ? "udiv_by_zero" : "sdiv_by_zero", lat, bb, 3, 32'hFFFF_FFFF, 32'd5, 1'b1);
        end
    endtask

    task automatic test_overflow;
        int lat, bb;
        pulse_start(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, bb);
        check_op("sdiv_overflow", lat, bb, 35, 32'h8000_0000, 32'd0, 1'b0);
    endtask

    task automatic test_start_while_busy;
        int lat, bb;
        pulse_start(1'b0, 32'd1000, 32'd10);
        repeat (9) @(negedge clk);
        bus.A_div_start  = 1'b1;
        bus.A_div_signed = 1'b1;
        bus.A_div_src1   = 32'd77;
        bus.A_div_src2   = 32'd3;
        @(negedge clk);
        bus.A_div_start  = 1'b0;
        wait_done(11, lat, bb);
        checks++;
        if (lat !== 35) begin errors++; $display("FAIL busy_start latency got %0d want 35", lat); end
        checks++;
        if (bus.A_div_quotient !== 32'd100 || bus.A_div_remainder !== 32'd0) begin
            errors++; $display("FAIL busy_start result q=%h r=%h want 64 0", bus.A_div_quotient, bus.A_div_remainder);
        end
        // Hold start across the DONE edge (ignored) and the following IDLE edge (accepted).
        bus.A_div_start  = 1'b1;
        bus.A_div_signed = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.A_div_busy !== 1'b0) begin errors++; $display("FAIL done_start busy got %b want 0", bus.A_div_busy); end
        @(negedge clk);
        bus.A_div_start = 1'b0;
        wait_done(1, lat, bb);
        check_op("idle_start_77_3", lat, bb, 35, 32'd25, 32'd2, 1'b0);
    endtask

    task automatic test_reset_mid_op;
        int lat, bb;
        pulse_start(1'b0, 32'd100, 32'd7);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({bus.A_div_busy, bus.A_div_done, bus.A_div_by_zero, bus.A_div_quotient, bus.A_div_remainder} !== 67'd0) begin
            errors++; $display("FAIL mid_reset outputs busy=%b done=%b q=%h r=%h want all 0",
                               bus.A_div_busy, bus.A_div_done, bus.A_div_quotient, bus.A_div_remainder);
        end
        pulse_start(1'b0, 32'hFFFF_FFFF, 32'h10);
        wait_done(1, lat, bb);
        check_op("post_reset_udiv", lat, bb, 35, 32'h0FFF_FFFF, 32'hF, 1'b0);
    endtask

    initial begin
        bus.A_div_start  = 1'b0;
        bus.A_div_signed = 1'b0;
        bus.A_div_src1   = '0;
        bus.A_div_src2   = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_by_zero();
        test_overflow();
        test_start_while_busy();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
